kernel_launcher: RTL and testbench

//  Host-side initiator for one GPU kernel launch. Writes thread count to the device control register, then holds start until done.

---
 rtl/kernel_launcher_pkg.sv | 16 +
 rtl/kernel_launcher_if.sv | 47 ++++
 rtl/kernel_launcher_cycle_watchdog.sv | 32 +++
 rtl/kernel_launcher.sv | 122 ++++++++++++
 tb/tb_kernel_launcher.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/kernel_launcher_pkg.sv
// Shared types and default widths for the kernel launcher.
package kernel_launcher_pkg;
  localparam int unsigned DEF_ADDR_BITS      = 8;
  localparam int unsigned DEF_DATA_BITS      = 8;
  localparam int unsigned DEF_DCR_BITS       = 8;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 4096;

  typedef enum logic [2:0] {
    S_IDLE, S_DCR, S_GAP, S_RUN, S_READ, S_OUT, S_FINISH, S_FAIL
  } state_e;

  // Counter width able to hold 1..t; a disabled watchdog still gets one bit.
  function automatic int unsigned wd_width(input int unsigned t);
    return (t == 0) ? 1 : $clog2(t + 1);
  endfunction
endpackage

// File: rtl/kernel_launcher_if.sv
// Host command, GPU control, data-memory read and result stream bundle.
interface kernel_launcher_if
  import kernel_launcher_pkg::*;
#(
  parameter int unsigned ADDR_BITS = DEF_ADDR_BITS,
  parameter int unsigned DATA_BITS = DEF_DATA_BITS,
  parameter int unsigned DCR_BITS  = DEF_DCR_BITS
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [DCR_BITS-1:0]  cmd_thread_count;
  logic [ADDR_BITS-1:0] cmd_rd_base;
  logic [ADDR_BITS:0]   cmd_rd_len;
  logic                 device_control_write_enable;
  logic [DCR_BITS-1:0]  device_control_data;
  logic                 start;
  logic                 done;
  logic                 mem_read_valid;
  logic [ADDR_BITS-1:0] mem_read_address;
  logic                 mem_read_ready;
  logic [DATA_BITS-1:0] mem_read_data;
  logic                 res_valid;
  logic                 res_ready;
  logic [DATA_BITS-1:0] res_data;
  logic [ADDR_BITS-1:0] res_index;
  logic                 busy;
  logic                 complete;
  logic                 error;

  // Launcher side
  modport master (
    input  cmd_valid, cmd_thread_count, cmd_rd_base, cmd_rd_len,
           done, mem_read_ready, mem_read_data, res_ready,
    output cmd_ready, device_control_write_enable, device_control_data, start,
           mem_read_valid, mem_read_address, res_valid, res_data, res_index,
           busy, complete, error
  );

  // Host / GPU / memory side
  modport slave (
    output cmd_valid, cmd_thread_count, cmd_rd_base, cmd_rd_len,
           done, mem_read_ready, mem_read_data, res_ready,
    input  cmd_ready, device_control_write_enable, device_control_data, start,
           mem_read_valid, mem_read_address, res_valid, res_data, res_index,
           busy, complete, error
  );
endinterface

// File: rtl/kernel_launcher_cycle_watchdog.sv
// Counts enabled cycles starting at 1; flags expiry on the TIMEOUT_CYCLES-th one.
module cycle_watchdog
  import kernel_launcher_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned WIDTH          = wd_width(TIMEOUT_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_expired
);
  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic w_unused;
      assign w_unused  = ^{clk, reset, i_enable, i_clear};
      assign o_expired = 1'b0;
    end else begin : g_on
      localparam logic [WIDTH-1:0] LIMIT = WIDTH'(TIMEOUT_CYCLES);
      logic [WIDTH-1:0] r_count;

      // Count enabled cycles; saturate at the limit so it can never wrap.
      always_ff @(posedge clk) begin
        if (!reset || i_clear)                 r_count <= WIDTH'(1);
        else if (i_enable && r_count != LIMIT) r_count <= r_count + 1'b1;
      end

      assign o_expired = i_enable && (r_count == LIMIT);
    end
  endgenerate
endmodule

// File: rtl/kernel_launcher.sv
// Launches one GPU kernel (DCR write, start/done), then streams back a result window.
module kernel_launcher
  import kernel_launcher_pkg::*;
#(
  parameter int unsigned ADDR_BITS      = DEF_ADDR_BITS,
  parameter int unsigned DATA_BITS      = DEF_DATA_BITS,
  parameter int unsigned DCR_BITS       = DEF_DCR_BITS,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic              clk,
  input logic              reset,
  kernel_launcher_if.master bus
);
  state_e               r_state, w_next;
  logic [DCR_BITS-1:0]  r_threads;
  logic [ADDR_BITS-1:0] r_base;
  logic [ADDR_BITS:0]   r_len;
  logic [ADDR_BITS:0]   r_idx;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_error;

  logic                 w_expired;
  logic                 w_run;
  logic [ADDR_BITS:0]   w_idx_inc;
  logic [ADDR_BITS-1:0] w_addr;

  assign w_run     = (r_state == S_RUN);
  assign w_idx_inc = r_idx + 1'b1;
  // Index is one bit wider than the address so a full 2^ADDR_BITS window ends; address wraps.
  assign w_addr    = r_base + r_idx[ADDR_BITS-1:0];

  cycle_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk      (clk),
    .reset    (reset),
    .i_enable (w_run),
    .i_clear  (!w_run),
    .o_expired(w_expired)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state and state-decoded outputs
  always_comb begin
    w_next                          = r_state;
    bus.cmd_ready                   = 1'b0;
    bus.device_control_write_enable = 1'b0;
    bus.device_control_data         = '0;
    bus.start                       = 1'b0;
    bus.mem_read_valid              = 1'b0;
    bus.mem_read_address            = '0;
    bus.res_valid                   = 1'b0;
    bus.res_data                    = '0;
    bus.res_index                   = '0;
    bus.complete                    = 1'b0;
    bus.busy                        = (r_state != S_IDLE);
    bus.error                       = r_error;
    case (r_state)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) w_next = S_DCR;
      end
      S_DCR: begin
        bus.device_control_write_enable = 1'b1;
        bus.device_control_data         = r_threads;
        w_next                          = S_GAP;
      end
      S_GAP: w_next = S_RUN;
      S_RUN: begin
        bus.start = 1'b1;
        // done wins over an expiry landing in the same cycle
        if (bus.done)      w_next = (r_len == '0) ? S_FINISH : S_READ;
        else if (w_expired) w_next = S_FAIL;
      end
      S_READ: begin
        bus.mem_read_valid   = 1'b1;
        bus.mem_read_address = w_addr;
        if (bus.mem_read_ready) w_next = S_OUT;
      end
      S_OUT: begin
        bus.res_valid = 1'b1;
        bus.res_data  = r_data;
        bus.res_index = r_idx[ADDR_BITS-1:0];
        if (bus.res_ready) w_next = (w_idx_inc == r_len) ? S_FINISH : S_READ;
      end
      S_FINISH: begin
        bus.complete = 1'b1;
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Command latch, index counter, read capture and sticky error
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_threads <= '0;
      r_base    <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_data    <= '0;
      r_error   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.cmd_valid) begin
          r_threads <= bus.cmd_thread_count;
          r_base    <= bus.cmd_rd_base;
          r_len     <= bus.cmd_rd_len;
          r_idx     <= '0;
          r_error   <= 1'b0;
        end
        S_RUN:  if (!bus.done && w_expired) r_error <= 1'b1;
        S_READ: if (bus.mem_read_ready)     r_data  <= bus.mem_read_data;
        S_OUT:  if (bus.res_ready)          r_idx   <= w_idx_inc;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_kernel_launcher.sv
// Directed bench: memory responder, GPU done stub, and a short-watchdog second instance.
module tb_kernel_launcher;
  localparam int unsigned AB = 8, DB = 8, CB = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  kernel_launcher_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .DCR_BITS(CB)) bus ();
  kernel_launcher_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .DCR_BITS(CB)) bus2 ();

  kernel_launcher #(.ADDR_BITS(AB), .DATA_BITS(DB), .DCR_BITS(CB), .TIMEOUT_CYCLES(4096)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  kernel_launcher #(.ADDR_BITS(AB), .DATA_BITS(DB), .DCR_BITS(CB), .TIMEOUT_CYCLES(16)) dut_wd (
    .clk(clk), .reset(reset), .bus(bus2));

  // memory responder: ready one cycle after valid, dropped on valid&ready
  logic [7:0] mem [0:255];
  logic       r_ready = 1'b0;
  logic       spur    = 1'b0;
  always @(posedge clk) begin
    r_ready           <= bus.mem_read_valid && !r_ready;
    bus.mem_read_data <= mem[bus.mem_read_address];
  end
  assign bus.mem_read_ready = r_ready | spur;

  // gpu stub: done after k_cycles of start
  int k_cycles = 200;
  int gcnt     = 0;
  always @(posedge clk) begin
    if (!bus.start) begin
      gcnt     <= 0;
      bus.done <= 1'b0;
    end else begin
      gcnt <= gcnt + 1;
      if (gcnt + 1 >= k_cycles) bus.done <= 1'b1;
    end
  end

  int n_vec = 0, n_err = 0;
  logic [31:0] exp_d [0:7];
  logic [31:0] exp_a [0:7];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // cmd accepted at cycle N; checks DCR at N+1, gap at N+2, start at N+3
  task automatic launch(input int thr, input int base, input int len);
    logic [31:0] t;
    t = thr;
    bus.cmd_thread_count = t[7:0];
    t = base;
    bus.cmd_rd_base      = t[7:0];
    t = len;
    bus.cmd_rd_len       = t[8:0];
    bus.cmd_valid        = 1'b1;
    chk("cmd_ready_idle", 32'(bus.cmd_ready), 1);
    tick();
    bus.cmd_valid = 1'b0;
    chk("dcr_we", 32'(bus.device_control_write_enable), 1);
    chk("dcr_data", 32'(bus.device_control_data), thr);
    chk("busy_dcr", 32'(bus.cmd_ready), 0);
    tick();
    chk("gap_we", 32'(bus.device_control_write_enable), 0);
    chk("gap_start", 32'(bus.start), 0);
    tick();
    chk("start_n3", 32'(bus.start), 1);
  endtask

  // follow one launch until complete; stall=1 holds res_ready low 5 cycles on the first word
  task automatic monitor(input int exp_n, input bit stall, input int budget);
    int got = 0, nrd = 0, ncomp = 0, cyc = 0, stall_cnt = 0, rv_cyc = 0;
    int fall_cyc = -1, comp_cyc = -2;
    logic [31:0] hd = 0, hi = 0;
    bit pstart = 1'b1, pdone = 1'b0, seen = 1'b0;
    bus.res_ready = !stall;
    while (!seen && cyc < budget) begin
      if (pstart && pdone) chk("start_drop", 32'(bus.start), 0);
      if (pstart && !bus.start) fall_cyc = cyc;
      if (bus.mem_read_valid) rv_cyc++;
      if (bus.mem_read_valid && bus.mem_read_ready && nrd < 8) begin
        chk("rd_addr", 32'(bus.mem_read_address), exp_a[nrd]);
        nrd++;
      end
      if (bus.res_valid && !bus.res_ready) begin
        if (stall_cnt == 0) begin
          hd = 32'(bus.res_data);
          hi = 32'(bus.res_index);
        end else begin
          chk("stall_data", 32'(bus.res_data), hd);
          chk("stall_idx", 32'(bus.res_index), hi);
        end
        chk("stall_rv", 32'(bus.mem_read_valid), 0);
        stall_cnt++;
        if (stall_cnt == 6) bus.res_ready = 1'b1;
      end
      if (bus.res_valid && bus.res_ready && got < 8) begin
        chk("res_data", 32'(bus.res_data), exp_d[got]);
        chk("res_idx", 32'(bus.res_index), got);
        got++;
      end
      if (bus.complete) begin
        seen     = 1'b1;
        comp_cyc = cyc;
        ncomp++;
      end
      pstart = bus.start;
      pdone  = bus.done;
      tick();
      cyc++;
    end
    chk("complete_seen", 32'(seen), 1);
    chk("complete_pulse", 32'(bus.complete), 0);
    chk("idle_after", 32'(bus.busy), 0);
    chk("n_words", got, exp_n);
    chk("n_reads", nrd, exp_n);
    if (exp_n == 0) begin
      chk("len0_no_rv", rv_cyc, 0);
      chk("len0_comp_at_fall", comp_cyc, fall_cyc);
    end
    if (stall) chk("stall_cycles", stall_cnt, 6);
    bus.res_ready = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5c);
    bus.cmd_valid = 1'b0; bus.cmd_thread_count = '0; bus.cmd_rd_base = '0; bus.cmd_rd_len = '0;
    bus.res_ready = 1'b1;
    bus2.cmd_valid = 1'b0; bus2.cmd_thread_count = '0; bus2.cmd_rd_base = '0; bus2.cmd_rd_len = '0;
    bus2.done = 1'b0; bus2.mem_read_ready = 1'b0; bus2.mem_read_data = '0; bus2.res_ready = 1'b1;

    // reset state
    reset = 1'b0;
    tick(); tick();
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_start", 32'(bus.start), 0);
    chk("rst_dcr_we", 32'(bus.device_control_write_enable), 0);
    chk("rst_rv", 32'(bus.mem_read_valid), 0);
    chk("rst_res_valid", 32'(bus.res_valid), 0);
    chk("rst_complete", 32'(bus.complete), 0);
    chk("rst_error", 32'(bus.error), 0);
    reset = 1'b1;
    tick();

    // watchdog on the TIMEOUT=16 instance, done never arrives
    bus2.cmd_thread_count = 8'd3; bus2.cmd_rd_len = 9'd1; bus2.cmd_valid = 1'b1;
    tick(); bus2.cmd_valid = 1'b0;
    tick(); tick();
    chk("wd_start_rise", 32'(bus2.start), 1);
    repeat (15) tick();
    chk("wd_start_n18", 32'(bus2.start), 1);
    chk("wd_err_n18", 32'(bus2.error), 0);
    tick();
    chk("wd_start_fail", 32'(bus2.start), 0);
    chk("wd_error_set", 32'(bus2.error), 1);
    chk("wd_busy_fail", 32'(bus2.busy), 1);
    tick();
    chk("wd_idle", 32'(bus2.busy), 0);
    chk("wd_error_sticky", 32'(bus2.error), 1);
    bus2.cmd_valid = 1'b1;
    tick(); bus2.cmd_valid = 1'b0;
    chk("wd_error_clear", 32'(bus2.error), 0);

    // basic launch
    mem[8] = 8'd7; mem[9] = 8'd10; mem[10] = 8'd15; mem[11] = 8'd22;
    exp_d[0] = 7; exp_d[1] = 10; exp_d[2] = 15; exp_d[3] = 22;
    for (int i = 0; i < 4; i++) exp_a[i] = 32'(8 + i);
    k_cycles = 200;
    launch(4, 8, 4);
    monitor(4, 1'b0, 600);

    // len = 0
    k_cycles = 20;
    launch(9, 8'h30, 0);
    monitor(0, 1'b0, 200);

    // result back-pressure
    mem[8'h20] = 8'ha5; mem[8'h21] = 8'h5a;
    exp_d[0] = 32'ha5; exp_d[1] = 32'h5a; exp_a[0] = 32'h20; exp_a[1] = 32'h21;
    k_cycles = 10;
    launch(1, 8'h20, 2);
    monitor(2, 1'b1, 200);

    // address wrap
    mem[8'hfe] = 8'h11; mem[8'hff] = 8'h22; mem[8'h00] = 8'h33; mem[8'h01] = 8'h44;
    exp_d[0] = 32'h11; exp_d[1] = 32'h22; exp_d[2] = 32'h33; exp_d[3] = 32'h44;
    exp_a[0] = 32'hfe; exp_a[1] = 32'hff; exp_a[2] = 32'h00; exp_a[3] = 32'h01;
    k_cycles = 5;
    launch(2, 8'hfe, 4);
    monitor(4, 1'b0, 200);

    // reset during READ, spurious ready, then a clean launch
    k_cycles = 30;
    launch(6, 8'h40, 3);
    for (int c = 0; c < 300 && !bus.mem_read_valid; c++) tick();
    chk("t6_in_read", 32'(bus.mem_read_valid), 1);
    reset = 1'b0;
    tick();
    chk("t6_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("t6_rv", 32'(bus.mem_read_valid), 0);
    chk("t6_addr", 32'(bus.mem_read_address), 0);
    chk("t6_busy", 32'(bus.busy), 0);
    chk("t6_start", 32'(bus.start), 0);
    chk("t6_res_valid", 32'(bus.res_valid), 0);
    reset = 1'b1;
    spur  = 1'b1;
    tick();
    spur = 1'b0;
    chk("t6_spur_busy", 32'(bus.busy), 0);
    chk("t6_spur_res", 32'(bus.res_valid), 0);
    mem[8'h40] = 8'h09; mem[8'h41] = 8'h08;
    exp_d[0] = 32'h09; exp_d[1] = 32'h08; exp_a[0] = 32'h40; exp_a[1] = 32'h41;
    k_cycles = 10;
    launch(2, 8'h40, 2);
    monitor(2, 1'b0, 200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
